// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  core_pkg : constants and types shared by the fetch and decode stages
//  Rev 1.0
// ============================================================================
package core_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  fetch_fifo : synchronous FIFO with clear; head is read from registered storage
//  Rev 1.0
// ============================================================================
module fetch_fifo #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]  PTR_MASK = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr + AW'(1)) & PTR_MASK;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr + AW'(1)) & PTR_MASK;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  fetch_unit : PC sequencing, credit-limited imem requests, response buffering
//  Rev 1.0
// ============================================================================
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        inst_ready_i
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit_used;
    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_resp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_after_retire;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;

    // Buffered entries plus in-flight requests may never exceed the FIFO size,
    // so every response that is kept always has a free slot.
    assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req_o    = !rst_i && !redirect_i && (w_credit_used < (CW+1)'(DEPTH));
    assign imem_addr_o   = r_fetch_pc;
    assign w_accept      = imem_req_o && imem_ready_i;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign w_resp         = imem_rvalid_i && (r_outstanding != '0);
    assign w_drop         = w_resp && (r_discard != '0);
    assign w_push         = w_resp && (r_discard == '0) && !redirect_i && !w_full;
    assign w_pop          = !w_empty && inst_ready_i && !redirect_i;
    assign w_after_retire = r_outstanding - (w_resp ? CW'(1) : CW'(0));

    assign w_push_entry.pc   = r_resp_pc;
    assign w_push_entry.inst = imem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect_i) begin
            r_fetch_pc    <= word_align(redirect_pc_i);
            r_resp_pc     <= word_align(redirect_pc_i);
            r_outstanding <= w_after_retire;
            r_discard     <= w_after_retire;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            r_outstanding <= w_after_retire + (w_accept ? CW'(1) : CW'(0));
            if (w_drop) begin
                r_discard <= r_discard - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (2 * XLEN),
        .RESET_VAL ({RESET_PC, NOP_INST}),
        .CW        (CW)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect_i),
        .i_data  (w_push_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign inst_valid_o = !w_empty;
    assign inst_o       = w_head.inst;
    assign pc_o         = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  tb_fetch_unit : randomized bench with a transaction-level fetch model
//  Rev 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_ready_i;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] pc; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;

    mem_req_t    mem_q[$];
    flight_t     inflight[$];
    entry_t      mfifo[$];
    logic [31:0] exp_fetch_pc;
    int          cyc      = 0;
    int          last_due = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          n_total  = 0;
    int          n_pass   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Drives one cycle, checks outputs against the model, then advances both.
    task automatic step(input bit rdy, input bit drdy, input bit redir, input logic [31:0] tgt);
        bit      rsp;
        bit      exp_req;
        bit      pop;
        int      lat;
        int      due;
        flight_t f;
        imem_ready_i  = rdy;
        inst_ready_i  = drdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        rsp           = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rvalid_i = rsp;
        imem_rdata_i  = rsp ? mem_word(mem_q[0].addr) : $urandom;
        #1;
        exp_req = !redir && ((mfifo.size() + inflight.size()) < DEPTH);
        check_eq("imem_req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req) check_eq("imem_addr", imem_addr_o, exp_fetch_pc);
        check_eq("inst_valid", 32'(inst_valid_o), 32'(mfifo.size() > 0));
        if (mfifo.size() > 0) begin
            check_eq("inst", inst_o, mfifo[0].inst);
            check_eq("pc", pc_o, mfifo[0].pc);
        end
        // memory side
        if (rsp) void'(mem_q.pop_front());
        if (imem_req_o && rdy) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{imem_addr_o, due});
        end
        // reference model
        pop = (mfifo.size() > 0) && drdy && !redir;
        if (redir) begin
            if (rsp && inflight.size() > 0) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            mfifo.delete();
            exp_fetch_pc = tgt & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(mfifo.pop_front());
            if (rsp && inflight.size() > 0) begin
                f = inflight.pop_front();
                if (!f.stale) mfifo.push_back('{f.pc, mem_word(f.pc)});
            end
            if (exp_req && rdy) begin
                inflight.push_back('{exp_fetch_pc, 1'b0});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_ready_i  = 1'b1;
        inst_ready_i  = 1'b0;
        #1;
        check_eq("req_in_reset", 32'(imem_req_o), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            cyc++;
            check_eq("rst_req", 32'(imem_req_o), 32'd0);
            check_eq("rst_valid", 32'(inst_valid_o), 32'd0);
            check_eq("rst_inst", inst_o, NOP);
            check_eq("rst_pc", pc_o, RESET_PC);
        end
        mem_q.delete();
        inflight.delete();
        mfifo.delete();
        exp_fetch_pc = RESET_PC;
        last_due     = cyc;
        rst_i        = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        imem_ready_i  = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        inst_ready_i  = 1'b0;
        do_reset(3);

        // streaming at latency 1
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, '0);
        // decode stalls, then releases
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);

        // redirect with two long-latency requests in flight
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, '0);

        // unaligned target, then wrap past the top of the address space
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF6);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);

        // random traffic, including back-to-back redirects
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0, $urandom);

        // reset with the FIFO full and requests outstanding
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
        do_reset(2);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 300; i++)
            step(($urandom % 3) != 0, ($urandom % 2) != 0, ($urandom % 30) == 0, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
